// File: rtl/irda_tx_pkg.sv
// irda_tx_pkg: shared defaults and helpers for the IrDA TX bit source
package irda_tx_pkg;
  localparam int DATA_W_DEF = 32;
  function automatic int lim_of(input int vbytes, input logic last, input int data_w);
    return (last && vbytes != 0 && 8 * vbytes <= data_w) ? 8 * vbytes - 1 : data_w - 1;
  endfunction
  function automatic int bit_idx(input int ptr, input logic msb_first, input int data_w);
    return msb_first ? data_w - 1 - ptr : ptr;
  endfunction
endpackage

// File: rtl/irda_tx_word_stage.sv
// irda_tx_word_stage: word holding register with last-bit limit and frame-last flag
module irda_tx_word_stage
  import irda_tx_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int PW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              load,
  input  logic              drop,
  input  logic [DATA_W-1:0] d,
  input  logic [PW-1:0]     d_lim,
  input  logic              d_last,
  output logic [DATA_W-1:0] q,
  output logic [PW-1:0]     lim,
  output logic              last,
  output logic              valid
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      q <= '0;
      lim <= '0;
      last <= 1'b0;
      valid <= 1'b0;
    end else if (flush) begin
      q <= '0;
      lim <= '0;
      last <= 1'b0;
      valid <= 1'b0;
    end else if (load) begin
      q <= d;
      lim <= d_lim;
      last <= d_last;
      valid <= 1'b1;
    end else if (drop)
      valid <= 1'b0;
endmodule

// File: rtl/irda_tx_data_ctrl.sv
// irda_tx_data_ctrl: prefetching FIFO-word to serial-bit source for the IrDA MIR/FIR encoder
module irda_tx_data_ctrl
  import irda_tx_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter bit MSB_FIRST = 1'b0,
  parameter int VB_W = 3
) (
  input  logic              clk,
  input  logic              wb_rst_n_i,
  input  logic              dc_restart,
  input  logic              tx_enable,
  input  logic              next_data,
  input  logic [DATA_W-1:0] txfifo_dat_o,
  input  logic              txfifo_empty,
  input  logic              txfifo_last,
  input  logic [VB_W-1:0]   txfifo_vbytes,
  output logic              txfifo_remove,
  output logic              data_available,
  output logic              data_o,
  output logic              frame_end,
  output logic              underrun
);
  localparam int PW = $clog2(DATA_W);
  logic remove_q, hr_valid, sr_last, hr_last;
  logic consume, done, act_free, mv, fetch, to_sr, sr_load;
  logic [DATA_W-1:0] sr, hr, sr_d;
  logic [PW-1:0] ptr, lim, hr_lim, f_lim, sr_lim_d;
  logic sr_last_d;
  always_comb begin
    consume = next_data && tx_enable && data_available;
    done = consume && ptr == lim;
    act_free = !data_available || done;
    mv = hr_valid && act_free;
    fetch = wb_rst_n_i && !dc_restart && !txfifo_empty && !remove_q && (!hr_valid || act_free);
    to_sr = fetch && act_free && !hr_valid;
    sr_load = mv || to_sr;
    f_lim = PW'(lim_of(int'(txfifo_vbytes), txfifo_last, DATA_W));
    sr_d = mv ? hr : txfifo_dat_o;
    sr_lim_d = mv ? hr_lim : f_lim;
    sr_last_d = mv ? hr_last : txfifo_last;
    txfifo_remove = fetch;
    data_o = data_available && sr[PW'(bit_idx(int'(ptr), MSB_FIRST, DATA_W))];
  end
  always_ff @(posedge clk or negedge wb_rst_n_i)
    if (!wb_rst_n_i) begin
      ptr <= '0;
      remove_q <= 1'b0;
      frame_end <= 1'b0;
      underrun <= 1'b0;
    end else if (dc_restart) begin
      ptr <= '0;
      remove_q <= 1'b0;
      frame_end <= 1'b0;
      underrun <= 1'b0;
    end else begin
      remove_q <= fetch;
      frame_end <= done && sr_last;
      underrun <= underrun || (done && !sr_last && !sr_load);
      ptr <= sr_load ? '0 : (consume && !done) ? ptr + 1'b1 : ptr;
    end
  irda_tx_word_stage #(.DATA_W(DATA_W), .PW(PW)) u_act (
    .clk(clk),
    .rst_n(wb_rst_n_i),
    .flush(dc_restart),
    .load(sr_load),
    .drop(done),
    .d(sr_d),
    .d_lim(sr_lim_d),
    .d_last(sr_last_d),
    .q(sr),
    .lim(lim),
    .last(sr_last),
    .valid(data_available)
  );
  irda_tx_word_stage #(.DATA_W(DATA_W), .PW(PW)) u_pre (
    .clk(clk),
    .rst_n(wb_rst_n_i),
    .flush(dc_restart),
    .load(fetch && !to_sr),
    .drop(mv),
    .d(txfifo_dat_o),
    .d_lim(f_lim),
    .d_last(txfifo_last),
    .q(hr),
    .lim(hr_lim),
    .last(hr_last),
    .valid(hr_valid)
  );
endmodule

// File: tb/tb_irda_tx_data_ctrl.sv
// tb_irda_tx_data_ctrl: vector-table, directed and randomized checks of irda_tx_data_ctrl
module tb_irda_tx_data_ctrl;
  typedef struct { logic [31:0] w; logic l; logic [2:0] v; } wd_t;
  typedef struct { logic [31:0] w; logic [2:0] v; int nb; logic [7:0] l8; logic [7:0] m8; int lones; int mones; } vec_t;
  typedef struct { logic b; logic bm; logic fe; } bit_t;
  logic clk = 1'b0, rst_n = 1'b1, restart = 1'b0, en = 1'b0, nd = 1'b0, empty = 1'b1, last = 1'b0;
  logic [31:0] dat = '0;
  logic [2:0] vb = '0;
  logic rem, av, dout, fe, ur, rem_m, av_m, dout_m, fe_m, ur_m;
  int checks = 0, errors = 0, nrem = 0;
  logic rem_seen = 1'b0, prev_rem = 1'b0;
  wd_t fq[$];
  vec_t tbl[5];

  irda_tx_data_ctrl #(.DATA_W(32), .MSB_FIRST(1'b0), .VB_W(3)) dut (
    .clk(clk), .wb_rst_n_i(rst_n), .dc_restart(restart), .tx_enable(en), .next_data(nd),
    .txfifo_dat_o(dat), .txfifo_empty(empty), .txfifo_last(last), .txfifo_vbytes(vb),
    .txfifo_remove(rem), .data_available(av), .data_o(dout), .frame_end(fe), .underrun(ur)
  );
  irda_tx_data_ctrl #(.DATA_W(32), .MSB_FIRST(1'b1), .VB_W(3)) dut_m (
    .clk(clk), .wb_rst_n_i(rst_n), .dc_restart(restart), .tx_enable(en), .next_data(nd),
    .txfifo_dat_o(dat), .txfifo_empty(empty), .txfifo_last(last), .txfifo_vbytes(vb),
    .txfifo_remove(rem_m), .data_available(av_m), .data_o(dout_m), .frame_end(fe_m), .underrun(ur_m)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog act=timeout req=finish");
    $fatal(1, "watchdog");
  end

  task automatic chkb(input string n, input logic a, input logic e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s act=%b req=%b", n, a, e);
    end
  endtask

  task automatic chki(input string n, input int a, input int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s act=%0d req=%0d", n, a, e);
    end
  endtask

  task automatic drv();
    empty = (fq.size() == 0);
    dat = empty ? '0 : fq[0].w;
    last = empty ? 1'b0 : fq[0].l;
    vb = empty ? 3'd0 : fq[0].v;
  endtask

  task automatic push(input logic [31:0] w, input logic l, input logic [2:0] v);
    wd_t x;
    x.w = w;
    x.l = l;
    x.v = v;
    fq.push_back(x);
    drv();
  endtask

  task automatic nxt();
    @(negedge clk);
    if (rem) begin
      nrem++;
      chkb("rem_gap", prev_rem, 1'b0);
      chkb("rem_empty", empty, 1'b0);
    end
    prev_rem = rem;
    rem_seen = rem;
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
    if (rem_seen && fq.size() > 0) fq.delete(0);
    rem_seen = 1'b0;
    drv();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    restart = 1'b0;
    en = 1'b0;
    nd = 1'b0;
    fq.delete();
    rem_seen = 1'b0;
    prev_rem = 1'b0;
    nrem = 0;
    drv();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic run_frame(input vec_t t);
    int n = 0, nm = 0, first = -1, lastc = -1, fec = -1, fen = 0, lo = 0, mo = 0;
    logic [7:0] l8 = '0, m8 = '0;
    do_reset();
    push(t.w, 1'b1, t.v);
    en = 1'b1;
    nd = 1'b1;
    for (int c = 0; c < 45; c++) begin
      nxt();
      if (av) begin
        if (first < 0) first = c;
        lastc = c;
        if (n < 8) l8 = {dout, l8[7:1]};
        lo += dout ? 1 : 0;
        n++;
      end
      if (av_m) begin
        if (nm < 8) m8 = {m8[6:0], dout_m};
        mo += dout_m ? 1 : 0;
        nm++;
      end
      if (fe) begin
        fen++;
        fec = c;
      end
      adv();
    end
    chki("latency", first, 1);
    chki("nbits", n, t.nb);
    chki("nbits_m", nm, t.nb);
    chki("contig", lastc - first + 1, n);
    chki("ones_lsb", lo, t.lones);
    chki("ones_msb", mo, t.mones);
    chki("byte_lsb", int'(l8), int'(t.l8));
    chki("byte_msb", int'(m8), int'(t.m8));
    chki("fe_cnt", fen, 1);
    chki("fe_at", fec, lastc + 1);
    chki("nrem", nrem, 1);
    chkb("ur_clean", ur, 1'b0);
    chkb("av_end", av, 1'b0);
  endtask

  task automatic rnd(input int nw, input int pn, input int pe);
    bit_t ex[$];
    bit_t b;
    logic fx = 1'b0, ave, eb, em, l;
    logic [31:0] w, t;
    logic [2:0] v;
    int nb;
    do_reset();
    for (int i = 0; i < nw; i++) begin
      w = $urandom;
      l = (i == nw - 1) || ($urandom_range(0, 2) == 0);
      v = 3'($urandom_range(0, 3));
      nb = (l && v != 0) ? 8 * int'(v) : 32;
      for (int k = 0; k < nb; k++) begin
        t = w >> k;
        b.b = t[0];
        t = w << k;
        b.bm = t[31];
        b.fe = l && k == nb - 1;
        ex.push_back(b);
      end
      push(w, l, v);
    end
    for (int c = 0; c < 4000; c++) begin
      if (ex.size() == 0 && !fx) break;
      nd = ($urandom_range(0, 99) < pn);
      en = ($urandom_range(0, 99) < pe);
      nxt();
      ave = c >= 1 && ex.size() > 0;
      eb = ave ? ex[0].b : 1'b0;
      em = ave ? ex[0].bm : 1'b0;
      chkb("r_av", av, ave);
      chkb("r_av_m", av_m, ave);
      chkb("r_dat", dout, eb);
      chkb("r_dat_m", dout_m, em);
      chkb("r_fe", fe, fx);
      chkb("r_ur", ur, 1'b0);
      fx = 1'b0;
      if (nd && en && ave) begin
        fx = ex[0].fe;
        ex.delete(0);
      end
      adv();
    end
    chki("r_drain", ex.size(), 0);
    chki("r_nrem", nrem, nw);
  endtask

  task automatic restart_test();
    logic [31:0] w3 = 32'h3C5A_9617;
    logic [7:0] by = '0;
    int n = 0;
    do_reset();
    push(32'h1111_2222, 1'b0, 3'd0);
    push(32'h7777_8888, 1'b1, 3'd0);
    push(w3, 1'b1, 3'd0);
    en = 1'b1;
    nd = 1'b1;
    for (int c = 0; c < 60 && n < 17; c++) begin
      nxt();
      if (av) n++;
      adv();
    end
    chki("rs_bits", n, 17);
    chki("rs_prefetch", nrem, 2);
    restart = 1'b1;
    nxt();
    chkb("rs_norem", rem, 1'b0);
    adv();
    restart = 1'b0;
    nxt();
    chkb("rs_av", av, 1'b0);
    chkb("rs_dat", dout, 1'b0);
    chkb("rs_fe", fe, 1'b0);
    chkb("rs_ur", ur, 1'b0);
    adv();
    n = 0;
    for (int c = 0; c < 30 && n < 8; c++) begin
      nxt();
      if (av) begin
        by = {dout, by[7:1]};
        n++;
      end
      adv();
    end
    chki("rs_w3", int'(by), int'(w3[7:0]));
  endtask

  task automatic hold_test();
    logic [31:0] w1 = 32'hC3A5_96E1, t;
    logic [7:0] by = '0;
    int n = 0, r0;
    do_reset();
    push(w1, 1'b1, 3'd0);
    en = 1'b1;
    nd = 1'b1;
    for (int c = 0; c < 20 && n < 5; c++) begin
      nxt();
      if (av) n++;
      adv();
    end
    en = 1'b0;
    push(32'h0F0F_F0F0, 1'b1, 3'd0);
    r0 = nrem;
    t = w1 >> 5;
    for (int c = 0; c < 10; c++) begin
      nxt();
      chkb("hold_dat", dout, t[0]);
      chkb("hold_av", av, 1'b1);
      adv();
    end
    chki("hold_rem", nrem - r0, 1);
    en = 1'b1;
    n = 0;
    for (int c = 0; c < 20 && n < 8; c++) begin
      nxt();
      if (av) begin
        by = {dout, by[7:1]};
        n++;
      end
      adv();
    end
    chki("hold_resume", int'(by), int'(t[7:0]));
  endtask

  task automatic ur_test();
    int n = 0, fen = 0, drop = -1, urc = -1;
    do_reset();
    nd = 1'b1;
    en = 1'b1;
    for (int c = 0; c < 3; c++) begin
      nxt();
      chkb("idle_ur", ur, 1'b0);
      chkb("idle_av", av, 1'b0);
      chkb("idle_dat", dout, 1'b0);
      adv();
    end
    push(32'h0000_0001, 1'b0, 3'd0);
    for (int c = 0; c < 40; c++) begin
      nxt();
      if (av) n++;
      if (fe) fen++;
      if (!av && n > 0 && drop < 0) drop = c;
      if (ur && urc < 0) urc = c;
      adv();
    end
    chki("ur_bits", n, 32);
    chki("ur_fe", fen, 0);
    chkb("ur_set", ur, 1'b1);
    chkb("ur_av", av, 1'b0);
    chki("ur_when", urc, drop);
    for (int c = 0; c < 5; c++) begin
      nxt();
      chkb("ur_sticky", ur, 1'b1);
      adv();
    end
    restart = 1'b1;
    nxt();
    adv();
    restart = 1'b0;
    nxt();
    chkb("ur_clr", ur, 1'b0);
    adv();
  endtask

  initial begin
    tbl[0] = '{32'hA5A5_0F0F, 3'd0, 32, 8'h0F, 8'hA5, 16, 16};
    tbl[1] = '{32'h8000_0001, 3'd1, 8, 8'h01, 8'h80, 1, 1};
    tbl[2] = '{32'h1234_5678, 3'd2, 16, 8'h78, 8'h12, 8, 5};
    tbl[3] = '{32'hDEAD_BEEF, 3'd3, 24, 8'hEF, 8'hDE, 18, 17};
    tbl[4] = '{32'hFFFF_FFFF, 3'd0, 32, 8'hFF, 8'hFF, 32, 32};
    #2;
    rst_n = 1'b0;
    push(32'hFFFF_FFFF, 1'b1, 3'd0);
    repeat (2) @(posedge clk);
    #1;
    chkb("rst_rem", rem, 1'b0);
    chkb("rst_av", av, 1'b0);
    chkb("rst_dat", dout, 1'b0);
    chkb("rst_fe", fe, 1'b0);
    chkb("rst_ur", ur, 1'b0);
    chkb("rst_av_m", av_m, 1'b0);
    for (int i = 0; i < 5; i++) run_frame(tbl[i]);
    rnd(3, 100, 100);
    rnd(40, 100, 100);
    rnd(40, 70, 80);
    restart_test();
    hold_test();
    ur_test();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/irda_tx_data_ctrl.md
Name: irda_tx_data_ctrl

Overview:
Parametrised TX bit-source for the IrDA MIR/FIR transmit paths. Pulls DATA_W-bit words from the TX FIFO and presents one un-stuffed data bit per next_data request to the encoder. Improvements over the first-generation controller:
- one-word prefetch buffer, so word boundaries cause no bubble;
- selectable bit order;
- partial last word of a frame (byte-granular);
- explicit frame-end and underrun reporting.

Parameters:
DATA_W, 32, FIFO word width in bits; multiple of 8, range 8..64.
MSB_FIRST, 0, 0 = bit 0 of the word is sent first; 1 = bit DATA_W-1 is sent first.
VB_W, 3, width of the valid-byte count; must hold DATA_W/8 - 1.

Ports:
clk  in  1  system clock
wb_rst_n_i  in  1  asynchronous active-low reset
dc_restart  in  1  synchronous flush; same effect as reset
tx_enable  in  1  transmitter enabled; next_data is ignored when low
next_data  in  1  encoder request: advance to the next bit
txfifo_dat_o  in  DATA_W  word at the FIFO head (valid when txfifo_empty=0)
txfifo_empty  in  1  FIFO empty
txfifo_last  in  1  head word is the last word of its frame
txfifo_vbytes  in  VB_W  valid bytes in a last word; 0 = all DATA_W/8 bytes
txfifo_remove  out  1  single-cycle pop of the FIFO head
data_available  out  1  data_o holds a valid bit
data_o  out  1  current data bit
frame_end  out  1  one-cycle pulse: final valid bit of a frame consumed
underrun  out  1  sticky: a frame ran dry mid-frame

Behaviour:
Reset and flush:
- Reset is asynchronous, active-low. All registers clear.
- Output reset values: txfifo_remove=0, data_available=0, data_o=0, frame_end=0, underrun=0.
- dc_restart is synchronous, has highest priority, and gives the same cleared state. Any remove pulse scheduled for that cycle is suppressed. Asserting it mid-word discards both the active and the prefetched words.

Storage:
- Active stage: sr (DATA_W bits), ptr, last-valid index lim, sr_last, data_available.
- Prefetch stage: hr, hr_lim, hr_last, hr_valid.
- On capture, lim = 8*vbytes-1 when txfifo_last=1 and vbytes!=0; otherwise lim = DATA_W-1.

Fetch from the FIFO:
- Fetch happens when txfifo_empty=0, txfifo_remove was 0 in the previous cycle, and a stage will be free at the clock edge.
- The word goes to sr if the active stage is empty and hr_valid=0; otherwise it goes to hr.
- txfifo_remove is asserted for exactly one cycle per captured word, in the same cycle as the capture.
- Removes are spaced at least 2 cycles apart, because the FIFO head updates one cycle after a pop.

Bit selection and consumption:
- Bit output: data_o = sr[ptr] when MSB_FIRST=0, or sr[DATA_W-1-ptr] when MSB_FIRST=1. data_o=0 whenever data_available=0.
- With MSB_FIRST=1, the valid bytes of a partial word are the high-order bytes.
- A bit is consumed when next_data && tx_enable && data_available.
- If ptr < lim, ptr increments.
- If ptr == lim (word done):
  - hr_valid=1: hr moves to sr and ptr=0 in the same cycle, so there is no bubble. hr may be refilled in that same cycle if the fetch rule allows.
  - hr_valid=0 and a fetch is possible this cycle: the FIFO word loads directly into sr.
  - Otherwise: data_available drops to 0 on the next cycle.
- frame_end pulses in the cycle after a done word with sr_last=1.
- underrun sets when a done word has sr_last=0 and no next word is available in the same cycle. It clears only on reset or dc_restart.

Other rules:
- next_data while data_available=0 is ignored and does not set underrun.
- tx_enable=0 freezes ptr; prefetching continues.
- Words of the next frame may be prefetched while the current frame finishes.
- Latency: FIFO non-empty to data_available=1 is 1 cycle, from an empty state.

Decomposition:
- Package irda_tx_pkg: DATA_W default, a byte-count-to-limit function, and a bit-index function for MSB/LSB ordering.
- One sub-module, irda_tx_word_stage: a holding register with data, lim and last. Instantiated twice, once for the active stage and once for the prefetch stage.

Test Plan:
- Reset, FIFO holds A5A5_0F0F (last=1, vbytes=0), next_data every cycle, MSB_FIRST=0 -> one remove pulse; data_o sequence 1,1,1,1,0,0,0,0,... for 32 bits; frame_end pulses once; data_available then returns to 0.
- Three back-to-back words pre-loaded, next_data every cycle -> 96 contiguous valid bits with no data_available gap at either word boundary; exactly 3 remove pulses, each ≥2 cycles apart.
- MSB_FIRST=1, word 8000_0001, last=1, vbytes=1 -> exactly 8 bits sent: 1,0,0,0,0,0,0,0; frame_end asserted after bit 8.
- Word 1 with last=0, FIFO empty thereafter, next_data continuous -> after 32 bits data_available=0 and underrun=1; underrun stays 1 until a dc_restart pulse clears it.
- Assert dc_restart at bit 17 with a prefetched word held -> next cycle all outputs 0, no remove in that cycle; the next FIFO word restarts at bit 0.
- Hold tx_enable=0 for 10 cycles mid-word with next_data=1 -> data_o constant, ptr unchanged; the prefetch still issues one remove.
